tt_um_hello_scroller: RTL and testbench

TT_UM_HELLO_SCROLLER -- requirements
Module: tt_um_hello_scroller

---
 rtl/hello_pkg.sv | 31 +++
 rtl/seg7_decode.sv | 37 +++
 rtl/tt_um_hello_scroller.sv | 123 ++++++++++++
 tb/tb_tt_um_hello_scroller.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/hello_pkg.sv
// Shared types and constants for the scrolling 7-segment message display:
// character codes, segment patterns, display modes and the default message.
package hello_pkg;

    typedef logic [7:0] char_t;
    typedef logic [6:0] seg_t;

    typedef enum logic [1:0] {
        MODE_SCROLL = 2'b00,
        MODE_MANUAL = 2'b01,
        MODE_COUNT  = 2'b10,
        MODE_LAMP   = 2'b11
    } mode_e;

    localparam seg_t SEG_BLANK = 7'h00;
    localparam seg_t SEG_ALL   = 7'h7F;
    localparam seg_t SEG_H     = 7'h76;
    localparam seg_t SEG_E     = 7'h79;
    localparam seg_t SEG_L     = 7'h38;
    localparam seg_t SEG_O     = 7'h3F;

    localparam char_t CHAR_BLANK = 8'h20;

    // Message characters are packed right-justified, index 0 in the most significant used byte.
    localparam logic [127:0] MSG_INIT_DEFAULT = {88'h0, "HELLO"};

    function automatic char_t hex_char(input logic [3:0] v);
        return (v < 4'd10) ? 8'h30 + {4'h0, v} : 8'h37 + {4'h0, v};
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational character-code to 7-segment decoder, segments {g,f,e,d,c,b,a}
// active high; unknown codes decode to blank.
module seg7_decode
    import hello_pkg::*;
(
    input  char_t code,
    output seg_t  seg
);

    always_comb begin
        // NOTE: default first so every path assigns seg and no latch is inferred.
        seg = SEG_BLANK;
        case (code)
            "0":     seg = 7'h3F;
            "1":     seg = 7'h06;
            "2":     seg = 7'h5B;
            "3":     seg = 7'h4F;
            "4":     seg = 7'h66;
            "5":     seg = 7'h6D;
            "6":     seg = 7'h7D;
            "7":     seg = 7'h07;
            "8":     seg = 7'h7F;
            "9":     seg = 7'h6F;
            "A":     seg = 7'h77;
            "B":     seg = 7'h7C;
            "C":     seg = 7'h39;
            "D":     seg = 7'h5E;
            "E":     seg = SEG_E;
            "F":     seg = 7'h71;
            "H":     seg = SEG_H;
            "L":     seg = SEG_L;
            "O":     seg = SEG_O;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/tt_um_hello_scroller.sv
// Message scroller: a speed-selectable prescaler ticks a scroll index or hex
// counter whose character is decoded and registered onto a 7-segment display.
module tt_um_hello_scroller
    import hello_pkg::*;
#(
    parameter int           MSG_LEN  = 5,
    parameter int           DIV_BASE = 1000,
    parameter logic [127:0] MSG_INIT = MSG_INIT_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    localparam int         PW       = $clog2(DIV_BASE * 128);
    localparam logic [3:0] LAST_IDX = 4'(MSG_LEN - 1);

    logic       run, dir, blank;
    logic [2:0] speed;
    mode_e      mode;
    logic [3:0] manual_idx;

    assign run        = ui_in[0];
    assign dir        = ui_in[1];
    assign speed      = ui_in[4:2];
    assign blank      = ui_in[5];
    assign mode       = mode_e'(ui_in[7:6]);
    assign manual_idx = uio_in[7:4];

    logic [PW-1:0] presc_q, period_m1;
    logic [2:0]    speed_q;
    logic          tick, tick_q;
    logic [3:0]    idx_q, idx_d, cnt_q, cnt_d, cur_idx;
    seg_t          seg_q, seg_d, dec_seg;
    char_t         code;

    // Shifting within PW bits wraps DIV_BASE<<7 to zero, so the minus one still lands right.
    assign period_m1 = (PW'(DIV_BASE) << speed) - PW'(1);
    assign tick      = ena && run && (speed == speed_q) && (presc_q == period_m1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q <= '0;
            speed_q <= '0;
        end else if (ena) begin
            // NOTE: non-blocking so every register samples pre-edge values regardless of order.
            speed_q <= speed;
            if (speed != speed_q)
                presc_q <= '0;
            else if (run)
                presc_q <= tick ? '0 : presc_q + PW'(1);
        end
    end

    always_comb begin
        idx_d = idx_q;
        cnt_d = cnt_q;
        case (mode)
            MODE_SCROLL:
                if (tick) begin
                    if (dir)
                        idx_d = (idx_q == 4'd0) ? LAST_IDX : idx_q - 4'd1;
                    else
                        idx_d = (idx_q >= LAST_IDX) ? 4'd0 : idx_q + 4'd1;
                end
            MODE_MANUAL: idx_d = manual_idx;
            MODE_COUNT:
                if (tick) cnt_d = dir ? cnt_q - 4'd1 : cnt_q + 4'd1;
            default: ;
        endcase
    end

    // Manual mode decodes straight from the pins to keep a single cycle of latency.
    assign cur_idx = (mode == MODE_MANUAL) ? manual_idx : idx_q;

    always_comb begin
        code = CHAR_BLANK;
        if (mode == MODE_COUNT)
            code = hex_char(cnt_q);
        else if (cur_idx <= LAST_IDX)
            code = MSG_INIT[{LAST_IDX - cur_idx, 3'b000} +: 8];
    end

    seg7_decode u_decode (
        .code (code),
        .seg  (dec_seg)
    );

    always_comb begin
        seg_d = dec_seg;
        if (mode == MODE_LAMP)
            seg_d = SEG_ALL;
        else if (blank)
            seg_d = SEG_BLANK;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q  <= '0;
            cnt_q  <= '0;
            seg_q  <= SEG_BLANK;
            tick_q <= 1'b0;
        end else if (ena) begin
            idx_q  <= idx_d;
            cnt_q  <= cnt_d;
            seg_q  <= seg_d;
            tick_q <= tick;
        end
    end

    assign uo_out  = {tick_q, seg_q};
    assign uio_out = {4'h0, idx_q};
    assign uio_oe  = 8'h0F;

    logic unused_ok;
    assign unused_ok = &{1'b0, uio_in[3:0]};

endmodule

// File: tb/tb_tt_um_hello_scroller.sv
// Self-checking bench for tt_um_hello_scroller with DIV_BASE = 4: a cycle model
// feeds a scoreboard, and directed checks confirm tick spacing and display sequences.
module tb_tt_um_hello_scroller;

    localparam int DIV = 4;

    logic       clk = 1'b0;
    logic       rst_n, ena;
    logic [7:0] ui_in, uio_in;
    wire  [7:0] uo_out, uio_out, uio_oe;

    always #5 clk = ~clk;

    tt_um_hello_scroller #(.MSG_LEN(5), .DIV_BASE(DIV)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uo_out  (uo_out),
        .uio_in  (uio_in),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    typedef struct packed {
        logic [7:0] uo;
        logic [7:0] uio;
    } smp_t;

    smp_t sb[$];
    smp_t log_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    logic [6:0] msg_seg [5]  = '{7'h76, 7'h79, 7'h38, 7'h38, 7'h3F};
    logic [6:0] hex_seg [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    int         m_pre;
    logic [2:0] m_spd;
    logic [3:0] m_idx, m_cnt;
    logic [6:0] m_seg;
    logic       m_tq;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_pre = 0;
        m_spd = 3'd0;
        m_idx = 4'd0;
        m_cnt = 4'd0;
        m_seg = 7'h00;
        m_tq  = 1'b0;
    endtask

    // Predict the state after the coming edge from the inputs now applied, then compare.
    task automatic cycle();
        smp_t       e;
        logic       tk;
        logic [3:0] iu;
        logic [2:0] spd;
        logic [1:0] md;
        spd = ui_in[4:2];
        md  = ui_in[7:6];
        tk  = 1'b0;
        if (ena) begin
            if (spd != m_spd) m_pre = 0;
            else if (ui_in[0]) begin
                if (m_pre == (DIV << spd) - 1) begin
                    m_pre = 0;
                    tk    = 1'b1;
                end else m_pre++;
            end
            m_spd = spd;
            iu = (md == 2'b01) ? uio_in[7:4] : m_idx;
            if (md == 2'b11)      m_seg = 7'h7F;
            else if (ui_in[5])    m_seg = 7'h00;
            else if (md == 2'b10) m_seg = hex_seg[m_cnt];
            else                  m_seg = (iu < 4'd5) ? msg_seg[iu] : 7'h00;
            if (md == 2'b01) m_idx = uio_in[7:4];
            else if (md == 2'b00 && tk)
                m_idx = ui_in[1] ? ((m_idx == 4'd0) ? 4'd4 : m_idx - 4'd1)
                                 : ((m_idx >= 4'd4) ? 4'd0 : m_idx + 4'd1);
            if (md == 2'b10 && tk) m_cnt = ui_in[1] ? m_cnt - 4'd1 : m_cnt + 4'd1;
            m_tq = tk;
        end
        sb.push_back({m_tq, m_seg, 4'h0, m_idx});
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check("uo_out", {24'h0, uo_out}, {24'h0, e.uo});
        check("uio_out", {24'h0, uio_out}, {24'h0, e.uio});
        check("uio_oe", {24'h0, uio_oe}, 32'h0F);
        log_q.push_back({uo_out, uio_out});
    endtask

    task automatic run_cycles(input int n);
        log_q.delete();
        for (int i = 0; i < n; i++) cycle();
    endtask

    // Called 1 time unit after an edge; reset is asserted away from any edge.
    task automatic pulse_reset(input string tag);
        #2 rst_n = 1'b0;
        #1;
        check({tag, "_uo"}, {24'h0, uo_out}, 32'h00);
        check({tag, "_uio"}, {24'h0, uio_out}, 32'h00);
        @(posedge clk);
        #1 rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        int ticks, first, second;
        rst_n  = 1'b1;
        ena    = 1'b1;
        ui_in  = 8'h00;
        uio_in = 8'h00;
        @(posedge clk);
        #1;
        pulse_reset("reset");
        check("reset_oe", {24'h0, uio_oe}, 32'h0F);

        // Scroll up at s=0: H E L L O H, one tick every 4 cycles.
        ui_in = 8'h01;
        run_cycles(24);
        for (int j = 0; j < 6; j++)
            check("scroll_seq", {25'h0, log_q[1 + 4 * j].uo[6:0]}, {25'h0, msg_seg[j % 5]});
        ticks = 0;
        first = -1;
        for (int i = 0; i < 24; i++)
            if (log_q[i].uo[7]) begin
                ticks++;
                if (first < 0) first = i;
            end
        check("tick_count_s0", ticks, 6);
        check("first_tick_s0", first, 3);

        // s=2, direction down from index 0: ticks every 16 cycles, wraps to O.
        pulse_reset("reset_dir");
        ui_in = 8'h0B;
        run_cycles(40);
        first  = -1;
        second = -1;
        for (int i = 0; i < 40; i++)
            if (log_q[i].uo[7]) begin
                if (first < 0) first = i;
                else if (second < 0) second = i;
            end
        check("tick_s2_first", first, 16);
        check("tick_s2_interval", second - first, 16);
        check("dir_down_idx", {24'h0, log_q[16].uio}, 32'h04);
        check("dir_down_seg", {25'h0, log_q[17].uo[6:0]}, 32'h3F);

        // Manual mode, including an out-of-range index.
        ui_in  = 8'h40;
        uio_in = 8'h20;
        run_cycles(1);
        check("manual_2", {25'h0, log_q[0].uo[6:0]}, 32'h38);
        uio_in = 8'h70;
        run_cycles(1);
        check("manual_7", {25'h0, log_q[0].uo[6:0]}, 32'h00);
        uio_in = 8'h00;

        // Count mode: 0..F then 0, blanking keeps counting.
        pulse_reset("reset_cnt");
        ui_in = 8'h81;
        run_cycles(68);
        for (int k = 0; k <= 16; k++)
            check("count_digit", {25'h0, log_q[4 * k].uo[6:0]}, {25'h0, hex_seg[k % 16]});
        ui_in = 8'hA1;
        run_cycles(8);
        check("blank_0", {25'h0, log_q[0].uo[6:0]}, 32'h00);
        check("blank_7", {25'h0, log_q[7].uo[6:0]}, 32'h00);
        ui_in = 8'h81;
        run_cycles(1);
        check("count_after_blank", {25'h0, log_q[0].uo[6:0]}, 32'h4F);

        // Lamp test overrides blank.
        ui_in = 8'hE1;
        run_cycles(1);
        check("lamp", {25'h0, log_q[0].uo[6:0]}, 32'h7F);

        // Freeze with ena low mid-period, then finish the remaining period.
        pulse_reset("reset_ena");
        ui_in = 8'h01;
        run_cycles(2);
        ena = 1'b0;
        run_cycles(20);
        ticks = 0;
        for (int i = 0; i < 20; i++) if (log_q[i].uo[7]) ticks++;
        check("ena_no_tick", ticks, 0);
        check("ena_idx_hold", {24'h0, log_q[19].uio}, 32'h00);
        ena = 1'b1;
        run_cycles(3);
        check("resume_no_tick", {31'h0, log_q[0].uo[7]}, 32'h0);
        check("resume_tick", {31'h0, log_q[1].uo[7]}, 32'h1);
        check("resume_idx", {24'h0, log_q[1].uio}, 32'h01);

        // Asynchronous reset mid-scroll, then restart at H.
        run_cycles(10);
        pulse_reset("reset_mid");
        run_cycles(2);
        check("restart_h", {25'h0, log_q[1].uo[6:0]}, 32'h76);
        check("restart_idx", {24'h0, log_q[1].uio}, 32'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
